// File: rtl/axis_fifo_arbiter.sv
// Round-robin arbiter merging two AXI-Stream producers onto one FIFO write port.
// Grants are bounded to BURST_LEN beats and per-requester beat counts are exported.
module axis_fifo_arbiter #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BURST_LEN        = 16,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_enable,
    output logic                        s0_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                        s0_axis_tvalid,
    output logic                        s1_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                        s1_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic [1:0]                  sts_grant,
    output logic [CNTR_WIDTH-1:0]       sts_cnt0,
    output logic [CNTR_WIDTH-1:0]       sts_cnt1
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    // Encoding doubles as the one-hot {s1,s0} grant status.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t                  state_q;
    logic                    last_grant_q;
    logic [BW-1:0]           beat_cnt_q;
    logic [CNTR_WIDTH-1:0]   cnt0_q;
    logic [CNTR_WIDTH-1:0]   cnt1_q;

    logic                    beat;
    logic                    rel_grant;
    logic                    pick_s1;
    logic [BW-1:0]           beat_cnt_d;
    logic [CNTR_WIDTH-1:0]   cnt0_d;
    logic [CNTR_WIDTH-1:0]   cnt1_d;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        unique case (state_q)
            GRANT0: begin
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tvalid  = s0_axis_tvalid;
                s0_axis_tready = m_axis_tready;
            end
            GRANT1: begin
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tvalid  = s1_axis_tvalid;
                s1_axis_tready = m_axis_tready;
            end
            default: ;
        endcase
    end

    assign beat       = m_axis_tvalid && m_axis_tready;
    // A stalled FIFO keeps the grant; only burst end, an idle requester or disable release it.
    assign rel_grant  = (beat && (beat_cnt_q == LAST_BEAT)) || !m_axis_tvalid || !cfg_enable;
    assign pick_s1    = s1_axis_tvalid && (!s0_axis_tvalid || !last_grant_q);
    assign beat_cnt_d = beat_cnt_q + 1'b1;
    assign cnt0_d     = cnt0_q + 1'b1;
    assign cnt1_d     = cnt1_q + 1'b1;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
                        state_q      <= pick_s1 ? GRANT1 : GRANT0;
                        last_grant_q <= pick_s1;
                        beat_cnt_q   <= '0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (beat) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (state_q == GRANT0) cnt0_q <= cnt0_d;
                        else                   cnt1_q <= cnt1_d;
                    end
                    if (rel_grant) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sts_grant = state_q;
    assign sts_cnt0  = cnt0_q;
    assign sts_cnt1  = cnt1_q;

endmodule
